// File: rtl/pipeline_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_pkg
//   Shared definitions for the first pipeline stage (instruction fetch):
//   the bubble opcode, the default reset vector, the stage-1 sequencing
//   state enum, and the PC increment helper used by the PC/RA storage.
// -----------------------------------------------------------------------------
package pipeline_pkg;

    localparam int PC_W    = 16;
    localparam int INSTR_W = 8;

    // Byte injected into stage 2 whenever no real opcode is delivered.
    localparam logic [INSTR_W-1:0] NOP_OPCODE_DEFAULT   = 8'h00;

    // PC value taken on reset.
    localparam logic [PC_W-1:0]    RESET_VECTOR_DEFAULT = 16'h0000;

    // Stage-1 sequencing states.
    typedef enum logic [1:0] {
        ST_WARM = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } stage1_state_t;

    // Sequential PC advance; wraps 16'hFFFF to 16'h0000 silently.
    function automatic logic [PC_W-1:0] pc_increment(input logic [PC_W-1:0] pc);
        return pc + 16'd1;
    endfunction

endpackage

// File: rtl/pipeline_stage1_pcra.sv
// -----------------------------------------------------------------------------
// pcra_regs
//   Program counter and return-address register pair.
//   Ports:
//     clk, rst_n      clock, asynchronous active-low reset
//     inc             advance PC by one (modulo 2^16)
//     load/load_value replace PC with a jump target
//     flip            exchange PC and RA in one edge
//     ra_load/_value  write RA; wins over the RA half of a flip
//     pc, ra          current register contents
//   PC priority is load > flip > inc. The caller must not assert load and
//   flip together, because the RA half of a flip is not suppressed here.
// -----------------------------------------------------------------------------
module pcra_regs
    import pipeline_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            inc,
    input  logic            load,
    input  logic [PC_W-1:0] load_value,
    input  logic            flip,
    input  logic            ra_load,
    input  logic [PC_W-1:0] ra_load_value,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] ra
);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] ra_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_VECTOR;
            ra_q <= '0;
        end else begin
            if (load) begin
                pc_q <= load_value;
            end else if (flip) begin
                pc_q <= ra_q;
            end else if (inc) begin
                pc_q <= pc_increment(pc_q);
            end

            // An explicit RA write overrides the RA side of a flip, while the
            // PC side of that flip still receives the old RA.
            if (ra_load) begin
                ra_q <= ra_load_value;
            end else if (flip) begin
                ra_q <= pc_q;
            end
        end
    end

    assign pc = pc_q;
    assign ra = ra_q;

endmodule

// File: rtl/pipeline_stage1.sv
// -----------------------------------------------------------------------------
// pipeline_stage1
//   Instruction fetch stage. Drives the PC onto the memory address bus, reads
//   one byte per cycle and registers it toward stage 2, injecting NOP bubbles
//   for jumps, PC/RA swaps, bus stalls, operand bytes and halts.
//   Ports:
//     clk, rst_n          clock, asynchronous active-low reset
//     mem_data            byte at fetch_addr, valid in the same cycle
//     bus_request         a later stage owns the memory bus this cycle
//     fetch_suppress      current byte is an operand, not an opcode
//     pc_load/_value      jump request and target
//     ra_load/_value      RA write (honoured in every state)
//     pcra_flip           swap PC and RA
//     break_in, resume    enter / leave HALT
//     fetch_addr          current PC
//     fetch_en            memory read strobe
//     instruction         registered byte to stage 2
//     instruction_pc      address the current instruction came from
//     ra_out              current RA
//     halted              high while in HALT
// -----------------------------------------------------------------------------
module pipeline_stage1
    import pipeline_pkg::*;
#(
    parameter logic [INSTR_W-1:0] NOP_OPCODE   = NOP_OPCODE_DEFAULT,
    parameter logic [PC_W-1:0]    RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INSTR_W-1:0] mem_data,
    input  logic               bus_request,
    input  logic               fetch_suppress,
    input  logic               pc_load,
    input  logic [PC_W-1:0]    pc_load_value,
    input  logic               ra_load,
    input  logic [PC_W-1:0]    ra_load_value,
    input  logic               pcra_flip,
    input  logic               break_in,
    input  logic               resume,
    output logic [PC_W-1:0]    fetch_addr,
    output logic               fetch_en,
    output logic [INSTR_W-1:0] instruction,
    output logic [PC_W-1:0]    instruction_pc,
    output logic [PC_W-1:0]    ra_out,
    output logic               halted
);

    stage1_state_t      state;
    stage1_state_t      state_next;

    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    ra;

    logic               pc_inc;
    logic               pc_jump;
    logic               pc_flip;
    logic               capture;
    logic [INSTR_W-1:0] instr_next;

    logic [INSTR_W-1:0] instr_q;
    logic [PC_W-1:0]    instr_pc_q;

    // Sequencing: decides what the PC/RA pair and the instruction register
    // do on the coming edge. Every path that does not capture a real opcode
    // leaves instr_next at the bubble value.
    always_comb begin
        state_next = state;
        pc_inc     = 1'b0;
        pc_jump    = 1'b0;
        pc_flip    = 1'b0;
        capture    = 1'b0;
        instr_next = NOP_OPCODE;

        unique case (state)
            ST_WARM: begin
                state_next = ST_RUN;
            end

            ST_RUN: begin
                if (pc_load) begin
                    pc_jump = 1'b1;
                end else if (pcra_flip) begin
                    pc_flip = 1'b1;
                end else if (break_in || bus_request) begin
                    // A break holds the PC just like a stall; a jump or
                    // flip in the same cycle still applies above.
                    pc_inc = 1'b0;
                end else if (fetch_suppress) begin
                    pc_inc = 1'b1;
                end else begin
                    pc_inc     = 1'b1;
                    capture    = 1'b1;
                    instr_next = mem_data;
                end

                if (break_in) begin
                    state_next = ST_HALT;
                end
            end

            ST_HALT: begin
                // A simultaneous break keeps the stage parked.
                if (resume && !break_in) begin
                    state_next = ST_RUN;
                end
            end

            default: begin
                state_next = ST_WARM;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_WARM;
            instr_q    <= NOP_OPCODE;
            instr_pc_q <= RESET_VECTOR;
        end else begin
            state   <= state_next;
            instr_q <= instr_next;
            if (capture) begin
                instr_pc_q <= pc;
            end
        end
    end

    pcra_regs #(
        .RESET_VECTOR (RESET_VECTOR)
    ) u_pcra_regs (
        .clk           (clk),
        .rst_n         (rst_n),
        .inc           (pc_inc),
        .load          (pc_jump),
        .load_value    (pc_load_value),
        .flip          (pc_flip),
        .ra_load       (ra_load),
        .ra_load_value (ra_load_value),
        .pc            (pc),
        .ra            (ra)
    );

    assign fetch_addr     = pc;
    assign fetch_en       = (state == ST_RUN) && !bus_request;
    assign instruction    = instr_q;
    assign instruction_pc = instr_pc_q;
    assign ra_out         = ra;
    assign halted         = (state == ST_HALT);

endmodule

// File: tb/tb_pipeline_stage1.sv
module tb_pipeline_stage1;

    logic        clk;
    logic        rst_n;
    logic [7:0]  mem_data;
    logic        bus_request;
    logic        fetch_suppress;
    logic        pc_load;
    logic [15:0] pc_load_value;
    logic        ra_load;
    logic [15:0] ra_load_value;
    logic        pcra_flip;
    logic        break_in;
    logic        resume;
    logic [15:0] fetch_addr;
    logic        fetch_en;
    logic [7:0]  instruction;
    logic [15:0] instruction_pc;
    logic [15:0] ra_out;
    logic        halted;

    int checks = 0;
    int errors = 0;

    pipeline_stage1 dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_data       (mem_data),
        .bus_request    (bus_request),
        .fetch_suppress (fetch_suppress),
        .pc_load        (pc_load),
        .pc_load_value  (pc_load_value),
        .ra_load        (ra_load),
        .ra_load_value  (ra_load_value),
        .pcra_flip      (pcra_flip),
        .break_in       (break_in),
        .resume         (resume),
        .fetch_addr     (fetch_addr),
        .fetch_en       (fetch_en),
        .instruction    (instruction),
        .instruction_pc (instruction_pc),
        .ra_out         (ra_out),
        .halted         (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory image: A5 at 0x0000, elsewhere lo^hi^3C.
    // 0001->3D 0002->3E 0010->2C 0040->7C FFFF->3C
    assign mem_data = (fetch_addr == 16'h0000) ? 8'hA5
                    : (fetch_addr[7:0] ^ fetch_addr[15:8] ^ 8'h3C);

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus_request    = 1'b0;
        fetch_suppress = 1'b0;
        pc_load        = 1'b0;
        pc_load_value  = 16'h0000;
        ra_load        = 1'b0;
        ra_load_value  = 16'h0000;
        pcra_flip      = 1'b0;
        break_in       = 1'b0;
        resume         = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        #3;
        checks++; if (fetch_addr !== 16'h0000) begin errors++; $display("FAIL rst_pc got %h want 0000", fetch_addr); end
        checks++; if (fetch_en !== 1'b0) begin errors++; $display("FAIL rst_fetch_en got %b want 0", fetch_en); end
        checks++; if (instruction !== 8'h00) begin errors++; $display("FAIL rst_instr got %h want 00", instruction); end
        checks++; if (instruction_pc !== 16'h0000) begin errors++; $display("FAIL rst_ipc got %h want 0000", instruction_pc); end
        checks++; if (ra_out !== 16'h0000) begin errors++; $display("FAIL rst_ra got %h want 0000", ra_out); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL rst_halted got %b want 0", halted); end
    endtask

    task automatic test_warm_start();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        checks++; if (fetch_en !== 1'b0) begin errors++; $display("FAIL warm_fetch_en got %b want 0", fetch_en); end
        tick();
        checks++; if (instruction !== 8'h00) begin errors++; $display("FAIL warm_instr got %h want 00", instruction); end
        checks++; if (fetch_addr !== 16'h0000) begin errors++; $display("FAIL warm_pc got %h want 0000", fetch_addr); end
        checks++; if (fetch_en !== 1'b1) begin errors++; $display("FAIL run_fetch_en got %b want 1", fetch_en); end
        tick();
        checks++; if (instruction !== 8'hA5) begin errors++; $display("FAIL first_instr got %h want a5", instruction); end
        checks++; if (instruction_pc !== 16'h0000) begin errors++; $display("FAIL first_ipc got %h want 0000", instruction_pc); end
        checks++; if (fetch_addr !== 16'h0001) begin errors++; $display("FAIL first_pc got %h want 0001", fetch_addr); end
    endtask

    task automatic test_back_to_back();
        tick();
        checks++; if (instruction !== 8'h3D) begin errors++; $display("FAIL b2b_instr1 got %h want 3d", instruction); end
        checks++; if (instruction_pc !== 16'h0001) begin errors++; $display("FAIL b2b_ipc1 got %h want 0001", instruction_pc); end
        tick();
        checks++; if (instruction !== 8'h3E) begin errors++; $display("FAIL b2b_instr2 got %h want 3e", instruction); end
        checks++; if (instruction_pc !== 16'h0002) begin errors++; $display("FAIL b2b_ipc2 got %h want 0002", instruction_pc); end
        checks++; if (fetch_addr !== 16'h0003) begin errors++; $display("FAIL b2b_pc got %h want 0003", fetch_addr); end
    endtask

    task automatic test_bus_request();
        pc_load = 1'b1; pc_load_value = 16'h0010;
        tick();
        clear_inputs();
        checks++; if (fetch_addr !== 16'h0010) begin errors++; $display("FAIL jump_pc got %h want 0010", fetch_addr); end
        checks++; if (instruction !== 8'h00) begin errors++; $display("FAIL jump_flush got %h want 00", instruction); end
        bus_request = 1'b1;
        #1;
        checks++; if (fetch_en !== 1'b0) begin errors++; $display("FAIL busreq_fetch_en got %b want 0", fetch_en); end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (instruction !== 8'h00) begin errors++; $display("FAIL busreq_instr[%0d] got %h want 00", i, instruction); end
            checks++; if (fetch_addr !== 16'h0010) begin errors++; $display("FAIL busreq_pc[%0d] got %h want 0010", i, fetch_addr); end
        end
        bus_request = 1'b0;
        #1;
        checks++; if (fetch_en !== 1'b1) begin errors++; $display("FAIL busrel_fetch_en got %b want 1", fetch_en); end
        tick();
        checks++; if (instruction !== 8'h2C) begin errors++; $display("FAIL busrel_instr got %h want 2c", instruction); end
        checks++; if (instruction_pc !== 16'h0010) begin errors++; $display("FAIL busrel_ipc got %h want 0010", instruction_pc); end
        checks++; if (fetch_addr !== 16'h0011) begin errors++; $display("FAIL busrel_pc got %h want 0011", fetch_addr); end
    endtask

    task automatic test_priority();
        pc_load = 1'b1; pc_load_value = 16'h1234;
        fetch_suppress = 1'b1; bus_request = 1'b1;
        tick();
        clear_inputs();
        checks++; if (fetch_addr !== 16'h1234) begin errors++; $display("FAIL prio_pc got %h want 1234", fetch_addr); end
        checks++; if (instruction !== 8'h00) begin errors++; $display("FAIL prio_instr got %h want 00", instruction); end
        checks++; if (instruction_pc !== 16'h0010) begin errors++; $display("FAIL prio_ipc got %h want 0010", instruction_pc); end
    endtask

    task automatic test_suppress();
        fetch_suppress = 1'b1;
        tick();
        clear_inputs();
        checks++; if (fetch_addr !== 16'h1235) begin errors++; $display("FAIL supp_pc got %h want 1235", fetch_addr); end
        checks++; if (instruction !== 8'h00) begin errors++; $display("FAIL supp_instr got %h want 00", instruction); end
        checks++; if (instruction_pc !== 16'h0010) begin errors++; $display("FAIL supp_ipc got %h want 0010", instruction_pc); end
    endtask

    task automatic test_wrap();
        pc_load = 1'b1; pc_load_value = 16'hFFFF;
        tick();
        clear_inputs();
        tick();
        checks++; if (fetch_addr !== 16'h0000) begin errors++; $display("FAIL wrap_pc got %h want 0000", fetch_addr); end
        checks++; if (instruction !== 8'h3C) begin errors++; $display("FAIL wrap_instr got %h want 3c", instruction); end
        checks++; if (instruction_pc !== 16'hFFFF) begin errors++; $display("FAIL wrap_ipc got %h want ffff", instruction_pc); end
    endtask

    task automatic test_flip();
        ra_load = 1'b1; ra_load_value = 16'h0200;
        tick();
        clear_inputs();
        checks++; if (ra_out !== 16'h0200) begin errors++; $display("FAIL raload_ra got %h want 0200", ra_out); end
        checks++; if (instruction !== 8'hA5) begin errors++; $display("FAIL raload_instr got %h want a5", instruction); end
        pc_load = 1'b1; pc_load_value = 16'h0100;
        tick();
        clear_inputs();
        pcra_flip = 1'b1; ra_load = 1'b1; ra_load_value = 16'h0300;
        tick();
        clear_inputs();
        checks++; if (fetch_addr !== 16'h0200) begin errors++; $display("FAIL flipld_pc got %h want 0200", fetch_addr); end
        checks++; if (ra_out !== 16'h0300) begin errors++; $display("FAIL flipld_ra got %h want 0300", ra_out); end
        checks++; if (instruction !== 8'h00) begin errors++; $display("FAIL flipld_instr got %h want 00", instruction); end
        pcra_flip = 1'b1;
        tick();
        clear_inputs();
        checks++; if (fetch_addr !== 16'h0300) begin errors++; $display("FAIL flip_pc got %h want 0300", fetch_addr); end
        checks++; if (ra_out !== 16'h0200) begin errors++; $display("FAIL flip_ra got %h want 0200", ra_out); end
        checks++; if (instruction_pc !== 16'h0000) begin errors++; $display("FAIL flip_ipc got %h want 0000", instruction_pc); end
    endtask

    task automatic test_halt();
        pc_load = 1'b1; pc_load_value = 16'h0040;
        tick();
        clear_inputs();
        break_in = 1'b1;
        tick();
        clear_inputs();
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL brk_halted got %b want 1", halted); end
        checks++; if (fetch_addr !== 16'h0040) begin errors++; $display("FAIL brk_pc got %h want 0040", fetch_addr); end
        checks++; if (instruction !== 8'h00) begin errors++; $display("FAIL brk_instr got %h want 00", instruction); end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (fetch_addr !== 16'h0040) begin errors++; $display("FAIL hold_pc[%0d] got %h want 0040", i, fetch_addr); end
            checks++; if (fetch_en !== 1'b0) begin errors++; $display("FAIL hold_fetch_en[%0d] got %b want 0", i, fetch_en); end
            checks++; if (halted !== 1'b1) begin errors++; $display("FAIL hold_halted[%0d] got %b want 1", i, halted); end
        end
        break_in = 1'b1; resume = 1'b1;
        tick();
        clear_inputs();
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL brkres_halted got %b want 1", halted); end
        ra_load = 1'b1; ra_load_value = 16'h0555;
        tick();
        clear_inputs();
        checks++; if (ra_out !== 16'h0555) begin errors++; $display("FAIL haltra_ra got %h want 0555", ra_out); end
        resume = 1'b1;
        tick();
        clear_inputs();
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL resume_halted got %b want 0", halted); end
        checks++; if (fetch_en !== 1'b1) begin errors++; $display("FAIL resume_fetch_en got %b want 1", fetch_en); end
        checks++; if (fetch_addr !== 16'h0040) begin errors++; $display("FAIL resume_pc got %h want 0040", fetch_addr); end
        tick();
        checks++; if (instruction !== 8'h7C) begin errors++; $display("FAIL resume_instr got %h want 7c", instruction); end
        checks++; if (instruction_pc !== 16'h0040) begin errors++; $display("FAIL resume_ipc got %h want 0040", instruction_pc); end
    endtask

    task automatic test_break_with_jump();
        pc_load = 1'b1; pc_load_value = 16'h0080; break_in = 1'b1;
        tick();
        clear_inputs();
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL brkjmp_halted got %b want 1", halted); end
        checks++; if (fetch_addr !== 16'h0080) begin errors++; $display("FAIL brkjmp_pc got %h want 0080", fetch_addr); end
    endtask

    task automatic test_reset_while_halted();
        pc_load = 1'b1; pc_load_value = 16'h0999;
        rst_n = 1'b0;
        #1;
        checks++; if (fetch_addr !== 16'h0000) begin errors++; $display("FAIL arst_pc got %h want 0000", fetch_addr); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL arst_halted got %b want 0", halted); end
        checks++; if (ra_out !== 16'h0000) begin errors++; $display("FAIL arst_ra got %h want 0000", ra_out); end
        checks++; if (instruction_pc !== 16'h0000) begin errors++; $display("FAIL arst_ipc got %h want 0000", instruction_pc); end
        tick();
        clear_inputs();
        rst_n = 1'b1;
        #1;
        checks++; if (fetch_en !== 1'b0) begin errors++; $display("FAIL arst_warm_fetch_en got %b want 0", fetch_en); end
        tick();
        checks++; if (fetch_en !== 1'b1) begin errors++; $display("FAIL arst_run_fetch_en got %b want 1", fetch_en); end
        checks++; if (fetch_addr !== 16'h0000) begin errors++; $display("FAIL arst_run_pc got %h want 0000", fetch_addr); end
        checks++; if (instruction !== 8'h00) begin errors++; $display("FAIL arst_run_instr got %h want 00", instruction); end
    endtask

    initial begin
        test_reset();
        test_warm_start();
        test_back_to_back();
        test_bus_request();
        test_priority();
        test_suppress();
        test_wrap();
        test_flip();
        test_halt();
        test_break_with_jump();
        test_reset_while_halted();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
